// File: rtl/mac_div.sv
// mac_div: radix-2 restoring unsigned divider, DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor.
// Latency: DIVIDEND_W cycles from accept to out_valid; one result per DIVIDEND_W+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY or DONE (no queueing).
// Optional build macro MAC_DIV_ZERO_BYPASS_EN: a zero divisor skips the iterations and goes
// straight to DONE; result values and flag are the same either way.
module mac_div #(
    parameter int DIVIDEND_W = 52,
    parameter int DIVISOR_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    // Dividend shift register; quotient bits enter at the LSB as dividend bits leave the MSB.
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    prem_q, prem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  zero_q, zero_d;
    // Output result registers, only touched when a result is produced.
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  dbz_q, dbz_d;

    // Trial subtract datapath signals.
    logic [DIVISOR_W+1:0]  shifted;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;
    logic [DIVISOR_W:0]    prem_next;
    logic [DIVIDEND_W-1:0] dvd_next;

    // Shift one dividend bit into the partial remainder and try subtracting the divisor.
    // The compare uses the full shifted width so a zero divisor (where the partial remainder
    // keeps growing) still always succeeds; when it fits, the difference never needs the top bit.
    always_comb begin
        shifted   = {prem_q, dvd_q[DIVIDEND_W-1]};
        fits      = (shifted >= {2'b00, dvs_q});
        diff      = shifted[DIVISOR_W:0] - {1'b0, dvs_q};
        prem_next = fits ? diff : shifted[DIVISOR_W:0];
        dvd_next  = {dvd_q[DIVIDEND_W-2:0], fits};
    end

    // Next-state and register-update logic for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    prem_d = '0;
                    cnt_d  = CNT_W'(DIVIDEND_W);
                    zero_d = (divisor == '0);
`ifdef MAC_DIV_ZERO_BYPASS_EN
                    if (divisor == '0) begin
                        // Publish the zero-divisor result without iterating.
                        quo_d   = '1;
                        rmd_d   = dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                prem_d = prem_next;
                dvd_d  = dvd_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quo_d   = dvd_next;
                    rmd_d   = prem_next[DIVISOR_W-1:0];
                    dbz_d   = zero_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Handshake outputs decode straight from the state register; results from their flops.
    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        out_valid   = (state_q == ST_DONE);
        quotient    = quo_q;
        remainder   = rmd_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_mac_div.sv
// Testbench for mac_div: vector table, hand-written corner sequences and a randomized
// back-to-back run checked against plain integer division.
module tb_mac_div;

    localparam int DW = 52;
    localparam int VW = 24;
`ifdef MAC_DIV_ZERO_BYPASS_EN
    // The bypass publishes the result on the accept edge itself.
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = DW;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    mac_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [DW-1:0] dvd;
        logic [VW-1:0] dvs;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Present operands, wait for acceptance, drop in_valid; t_acc is the accept edge index.
    task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                            output longint t_acc, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        t_acc    = cyc;
    endtask

    // Wait (bounded) for out_valid, sampled on negedges; lat counts edges after the accept edge.
    task automatic wait_valid(input int budget, input longint t_acc,
                              output longint lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            if (out_valid) begin
                ok  = 1'b1;
                lat = cyc - t_acc;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t   vecs[6];
    longint t_acc, lat, prev_rise;
    bit     ok, stable, seen;
    logic [DW-1:0] ea, eb_dvd;
    logic [VW-1:0] eb, eb_dvs;
    logic [63:0]   tmp, qe, re;

    initial begin
        vecs[0] = '{dvd: 52'd0,             dvs: 24'd5,        q: 52'd0,             r: 24'd0,        z: 1'b0, lat: DW};
        vecs[1] = '{dvd: 52'd5,             dvs: 24'd10,       q: 52'd0,             r: 24'd5,        z: 1'b0, lat: DW};
        vecs[2] = '{dvd: 52'hFFFFFE000001,  dvs: 24'hFFFFFF,   q: 52'hFFFFFF,        r: 24'd0,        z: 1'b0, lat: DW};
        vecs[3] = '{dvd: 52'hFFFFFFFFFFFFF, dvs: 24'd1,        q: 52'hFFFFFFFFFFFFF, r: 24'd0,        z: 1'b0, lat: DW};
        vecs[4] = '{dvd: 52'h123456789,     dvs: 24'd0,        q: 52'hFFFFFFFFFFFFF, r: 24'h456789,   z: 1'b1, lat: ZLAT};
        vecs[5] = '{dvd: 52'd100,           dvs: 24'd7,        q: 52'd14,            r: 24'd2,        z: 1'b0, lat: DW};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready",    64'(in_ready),    64'd1);
        check("reset out_valid",   64'(out_valid),   64'd0);
        check("reset quotient",    64'(quotient),    64'd0);
        check("reset remainder",   64'(remainder),   64'd0);
        check("reset div_by_zero", 64'(div_by_zero), 64'd0);

        // Directed vectors, out_ready held high.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].dvd, vecs[i].dvs, t_acc, ok);
            check($sformatf("vec%0d accepted", i), 64'(ok), 64'd1);
            wait_valid(200, t_acc, lat, ok);
            check($sformatf("vec%0d out_valid seen", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d quotient", i), 64'(quotient), 64'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), 64'(remainder), 64'(vecs[i].r));
            check($sformatf("vec%0d div_by_zero", i), 64'(div_by_zero), 64'(vecs[i].z));
            @(negedge clk);
            check($sformatf("vec%0d out_valid one cycle", i), 64'(out_valid), 64'd0);
        end

        // Reset in the middle of 1000/3, after 20 iterations.
        start_op(52'd1000, 24'd3, t_acc, ok);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset in_ready",    64'(in_ready),    64'd1);
        check("midreset out_valid",   64'(out_valid),   64'd0);
        check("midreset quotient",    64'(quotient),    64'd0);
        check("midreset remainder",   64'(remainder),   64'd0);
        check("midreset div_by_zero", 64'(div_by_zero), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midreset no stale result", 64'(seen), 64'd0);
        start_op(52'd9, 24'd4, t_acc, ok);
        wait_valid(200, t_acc, lat, ok);
        check("after reset 9/4 seen",      64'(ok),        64'd1);
        check("after reset 9/4 quotient",  64'(quotient),  64'd2);
        check("after reset 9/4 remainder", 64'(remainder), 64'd1);
        @(negedge clk);

        // Backpressure: result held for 10 cycles while new operands wait.
        out_ready = 1'b0;
        ea = 52'd1000000;
        eb = 24'd13;
        start_op(ea, eb, t_acc, ok);
        wait_valid(200, t_acc, lat, ok);
        check("bp first result seen", 64'(ok), 64'd1);
        eb_dvd   = 52'd77777;
        eb_dvs   = 24'd11;
        dividend = eb_dvd;
        divisor  = eb_dvs;
        in_valid = 1'b1;
        stable   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (quotient !== 52'(ea / 52'(eb)) || remainder !== 24'(ea % 52'(eb)) ||
                in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("bp held result stable", 64'(stable), 64'd1);
        check("bp held quotient", 64'(quotient), 64'(ea / 52'(eb)));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp out_valid dropped", 64'(out_valid), 64'd0);
        check("bp in_ready returned", 64'(in_ready),  64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        t_acc    = cyc;
        check("bp new op accepted", 64'(in_ready), 64'd0);
        wait_valid(200, t_acc, lat, ok);
        check("bp second latency",   64'(lat),       64'(DW));
        check("bp second quotient",  64'(quotient),  64'(eb_dvd / 52'(eb_dvs)));
        check("bp second remainder", 64'(remainder), 64'(eb_dvd % 52'(eb_dvs)));
        @(negedge clk);

        // Randomized back-to-back run with in_valid and out_ready held high.
        prev_rise = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int          w;
            int unsigned m;
            tmp = {$urandom(), $urandom()};
            ea  = tmp[DW-1:0];
            w   = $urandom_range(1, VW);
            m   = (32'd1 << w) - 32'd1;
            eb  = VW'($urandom() & m);
            if (eb == '0) eb = 24'd1;
            qe  = 64'(ea) / 64'(eb);
            re  = 64'(ea) % 64'(eb);
            dividend = ea;
            divisor  = eb;
            in_valid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            @(negedge clk);
            t_acc = cyc;
            wait_valid(200, t_acc, lat, ok);
            check($sformatf("rand%0d seen", i), 64'(ok), 64'd1);
            check($sformatf("rand%0d quotient", i), 64'(quotient), qe);
            check($sformatf("rand%0d remainder", i), 64'(remainder), re);
            if (i > 0) check($sformatf("rand%0d interval", i), 64'(cyc - prev_rise), 64'(DW + 2));
            prev_rise = cyc;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
